// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, bundle bit positions, ALUOp codes and forwarding selects for the
// pipeline control path.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned EX_W  = 4;
  localparam int unsigned MEM_W = 3;
  localparam int unsigned WB_W  = 2;
  localparam int unsigned FWD_W = 2;

  // EX bundle {RegDst, ALUOp[1:0], ALUSrc}
  localparam int unsigned EX_REGDST   = 3;
  localparam int unsigned EX_ALUOP_HI = 2;
  localparam int unsigned EX_ALUOP_LO = 1;
  localparam int unsigned EX_ALUSRC   = 0;

  // MEM bundle {MemRead, MemWrite, Branch}
  localparam int unsigned MEM_MEMREAD  = 2;
  localparam int unsigned MEM_MEMWRITE = 1;
  localparam int unsigned MEM_BRANCH   = 0;

  // WB bundle {RegWrite, MemtoReg}
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [FWD_W-1:0] FWD_REGFILE = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM   = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEMWB   = 2'b01;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } id_regs_t;

  // Register match that never fires on $0
  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != REG_W'(0)) && (a == b);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// Combinational stall and forwarding-select logic.
// PIPE_CTRL_FWD_EN: defined = forwarding + load-use stall; undefined = no forwarding, RAW stalls.
module pipe_hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               ex_memread,
  input  logic               ex_regwrite,
  input  logic [REG_W-1:0]   ex_rs,
  input  logic [REG_W-1:0]   ex_rt,
  input  logic [REG_W-1:0]   ex_dst,
  input  logic               mem_regwrite,
  input  logic [REG_W-1:0]   mem_dst,
  input  logic               wb_regwrite,
  input  logic [REG_W-1:0]   wb_dst,
  input  logic               pc_src,
  output logic               stall_c,
  output logic [2*FWD_W-1:0] fwd_sel_c
);

  logic load_use;

  always_comb begin
    load_use = ex_memread && (reg_match(ex_rt, id_rs) || reg_match(ex_rt, id_rt));
  end

`ifdef PIPE_CTRL_FWD_EN

  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic             unused_nofwd;

  assign unused_nofwd = ^{ex_regwrite, ex_dst};

  // Youngest producer (EX/MEM) wins over MEM/WB
  always_comb begin
    fwd_a = FWD_REGFILE;
    fwd_b = FWD_REGFILE;
    if (mem_regwrite && reg_match(mem_dst, ex_rs)) begin
      fwd_a = FWD_EXMEM;
    end else if (wb_regwrite && reg_match(wb_dst, ex_rs)) begin
      fwd_a = FWD_MEMWB;
    end
    if (mem_regwrite && reg_match(mem_dst, ex_rt)) begin
      fwd_b = FWD_EXMEM;
    end else if (wb_regwrite && reg_match(wb_dst, ex_rt)) begin
      fwd_b = FWD_MEMWB;
    end
  end

  always_comb begin
    stall_c   = load_use && !pc_src;
    fwd_sel_c = {fwd_a, fwd_b};
  end

`else

  logic raw_ex;
  logic raw_mem;
  logic unused_fwd;

  assign unused_fwd = ^{ex_rs, wb_regwrite, wb_dst};

  // Without bypassing, ID must wait until producers in EX and MEM reach WB
  always_comb begin
    raw_ex    = ex_regwrite && (reg_match(ex_dst, id_rs) || reg_match(ex_dst, id_rt));
    raw_mem   = mem_regwrite && (reg_match(mem_dst, id_rs) || reg_match(mem_dst, id_rt));
    stall_c   = (load_use || raw_ex || raw_mem) && !pc_src;
    fwd_sel_c = '0;
  end

`endif

endmodule

// File: rtl/pipe_ctrl_stages.sv
// ID/EX, EX/MEM and MEM/WB control registers with bubble/flush insertion.
// Forwarding is enabled with PIPE_CTRL_FWD_EN (see pipe_hazard_unit).
module pipe_ctrl_stages
  import pipe_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EX_W-1:0]      ex_in,
  input  logic [MEM_W-1:0]     mem_in,
  input  logic [WB_W-1:0]      wb_in,
  input  logic                 jump_in,
  input  logic [3*REG_W-1:0]   id_regs,
  input  logic                 alu_zero,
  output logic [EX_W-1:0]      ex_ctrl,
  output logic [1:0]           mem_ctrl,
  output logic                 pc_src,
  output logic [WB_W-1:0]      wb_ctrl,
  output logic [REG_W-1:0]     wb_dst,
  output logic                 stall,
  output logic                 flush_ifid,
  output logic [2*FWD_W-1:0]   fwd_sel
);

  id_regs_t         id_r;
  logic [MEM_W-1:0] id_mem_c;
  logic             squash_idex;

  logic [EX_W-1:0]  idex_ex;
  logic [MEM_W-1:0] idex_mem;
  logic [WB_W-1:0]  idex_wb;
  id_regs_t         idex_regs;
  logic [REG_W-1:0] ex_dst;

  logic [1:0]       exmem_mem;
  logic             exmem_branch;
  logic             exmem_zero;
  logic [WB_W-1:0]  exmem_wb;
  logic [REG_W-1:0] exmem_dst;

  logic [WB_W-1:0]  memwb_wb;
  logic [REG_W-1:0] memwb_dst;

  logic             stall_c;
  logic             pc_src_c;
  logic [2*FWD_W-1:0] fwd_sel_c;

  assign id_r = id_regs_t'(id_regs);

  // Decoder flags J/JR as Branch; only real branches may reach the MEM resolve
  always_comb begin
    id_mem_c             = mem_in;
    id_mem_c[MEM_BRANCH] = mem_in[MEM_BRANCH] & ~jump_in;
    squash_idex          = stall_c | pc_src_c;
  end

  always_comb begin
    ex_dst = idex_ex[EX_REGDST] ? idex_regs.rd : idex_regs.rt;
  end

  // ID/EX: register fields always captured, control zeroed on bubble or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ex   <= '0;
      idex_mem  <= '0;
      idex_wb   <= '0;
      idex_regs <= '0;
    end else begin
      idex_regs <= id_r;
      if (squash_idex) begin
        idex_ex  <= '0;
        idex_mem <= '0;
        idex_wb  <= '0;
      end else begin
        idex_ex  <= ex_in;
        idex_mem <= id_mem_c;
        idex_wb  <= wb_in;
      end
    end
  end

  // EX/MEM: a taken branch kills the instruction behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_mem    <= '0;
      exmem_branch <= 1'b0;
      exmem_zero   <= 1'b0;
      exmem_wb     <= '0;
      exmem_dst    <= '0;
    end else begin
      exmem_zero <= alu_zero;
      exmem_dst  <= ex_dst;
      if (pc_src_c) begin
        exmem_mem    <= '0;
        exmem_branch <= 1'b0;
        exmem_wb     <= '0;
      end else begin
        exmem_mem    <= {idex_mem[MEM_MEMREAD], idex_mem[MEM_MEMWRITE]};
        exmem_branch <= idex_mem[MEM_BRANCH];
        exmem_wb     <= idex_wb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memwb_wb  <= '0;
      memwb_dst <= '0;
    end else begin
      memwb_wb  <= exmem_wb;
      memwb_dst <= exmem_dst;
    end
  end

  assign pc_src_c = exmem_branch & exmem_zero;

  pipe_hazard_unit u_hazard (
    .id_rs        (id_r.rs),
    .id_rt        (id_r.rt),
    .ex_memread   (idex_mem[MEM_MEMREAD]),
    .ex_regwrite  (idex_wb[WB_REGWRITE]),
    .ex_rs        (idex_regs.rs),
    .ex_rt        (idex_regs.rt),
    .ex_dst       (ex_dst),
    .mem_regwrite (exmem_wb[WB_REGWRITE]),
    .mem_dst      (exmem_dst),
    .wb_regwrite  (memwb_wb[WB_REGWRITE]),
    .wb_dst       (memwb_dst),
    .pc_src       (pc_src_c),
    .stall_c      (stall_c),
    .fwd_sel_c    (fwd_sel_c)
  );

  // jump_in is a raw ID input, so flush is gated to keep reset outputs quiet
  always_comb begin
    ex_ctrl    = idex_ex;
    mem_ctrl   = exmem_mem;
    pc_src     = pc_src_c;
    wb_ctrl    = memwb_wb;
    wb_dst     = memwb_dst;
    stall      = stall_c;
    flush_ifid = ~rst & (pc_src_c | (jump_in & ~stall_c));
    fwd_sel    = fwd_sel_c;
  end

endmodule

// File: tb/tb_pipe_ctrl_stages.sv
// Directed bench for pipe_ctrl_stages; expectations follow PIPE_CTRL_FWD_EN.
module tb_pipe_ctrl_stages;

  localparam logic [3:0] EX_R   = 4'b1100;
  localparam logic [3:0] EX_LW  = 4'b0001;
  localparam logic [3:0] EX_BEQ = 4'b0010;
  localparam logic [2:0] MEM_LW = 3'b100;
  localparam logic [2:0] MEM_BR = 3'b001;
  localparam logic [1:0] WB_R   = 2'b10;
  localparam logic [1:0] WB_LW  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ex_in = '0;
  logic [2:0]  mem_in = '0;
  logic [1:0]  wb_in = '0;
  logic        jump_in = 1'b0;
  logic [14:0] id_regs = '0;
  logic        alu_zero = 1'b0;
  logic [3:0]  ex_ctrl;
  logic [1:0]  mem_ctrl;
  logic        pc_src;
  logic [1:0]  wb_ctrl;
  logic [4:0]  wb_dst;
  logic        stall;
  logic        flush_ifid;
  logic [3:0]  fwd_sel;
  logic [19:0] all_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pipe_ctrl_stages dut (
    .clk        (clk),
    .rst        (rst),
    .ex_in      (ex_in),
    .mem_in     (mem_in),
    .wb_in      (wb_in),
    .jump_in    (jump_in),
    .id_regs    (id_regs),
    .alu_zero   (alu_zero),
    .ex_ctrl    (ex_ctrl),
    .mem_ctrl   (mem_ctrl),
    .pc_src     (pc_src),
    .wb_ctrl    (wb_ctrl),
    .wb_dst     (wb_dst),
    .stall      (stall),
    .flush_ifid (flush_ifid),
    .fwd_sel    (fwd_sel)
  );

  assign all_out = {ex_ctrl, mem_ctrl, pc_src, wb_ctrl, wb_dst, stall, flush_ifid, fwd_sel};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                       input logic j, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    ex_in   = ex;
    mem_in  = mem;
    wb_in   = wb;
    jump_in = j;
    id_regs = {rs, rt, rd};
    #1;
  endtask

  task automatic drain();
    drive('0, '0, '0, 1'b0, '0, '0, '0);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_zero = 1'b1;
    drive(EX_R, MEM_BR, WB_R, 1'b1, 5'd1, 5'd2, 5'd3);
    n_vec++;
    if (all_out !== 20'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected all zero", all_out);
    end
    tick();
    n_vec++;
    if (all_out !== 20'd0) begin
      n_err++;
      $display("FAIL reset_after_edge: got %b expected all zero", all_out);
    end
    rst = 1'b0;
    alu_zero = 1'b0;
    drain();
  endtask

  task automatic test_rtype();
    drive(EX_R, 3'b000, WB_R, 1'b0, 5'd1, 5'd2, 5'd5);
    tick();
    n_vec++;
    if ({ex_ctrl, wb_ctrl} !== {EX_R, 2'b00}) begin
      n_err++;
      $display("FAIL rtype_plus1: got ex=%b wb=%b expected ex=1100 wb=00", ex_ctrl, wb_ctrl);
    end
    drive('0, '0, '0, 1'b0, '0, '0, '0);
    tick();
    n_vec++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 8'd0) begin
      n_err++;
      $display("FAIL rtype_plus2: got ex=%b mem=%b wb=%b expected zeros", ex_ctrl, mem_ctrl, wb_ctrl);
    end
    tick();
    n_vec++;
    if ({wb_ctrl, wb_dst} !== {2'b10, 5'd5}) begin
      n_err++;
      $display("FAIL rtype_plus3: got wb=%b dst=%0d expected wb=10 dst=5", wb_ctrl, wb_dst);
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(EX_LW, MEM_LW, WB_LW, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    drive(EX_R, 3'b000, WB_R, 1'b0, 5'd2, 5'd3, 5'd4);
    n_vec++;
    if ({stall, flush_ifid} !== 2'b10) begin
      n_err++;
      $display("FAIL loaduse_stall: got stall=%b flush=%b expected 1 0", stall, flush_ifid);
    end
    tick();
    n_vec++;
    if ({ex_ctrl, mem_ctrl} !== {4'b0000, 2'b10}) begin
      n_err++;
      $display("FAIL loaduse_bubble: got ex=%b mem=%b expected 0000 10", ex_ctrl, mem_ctrl);
    end
`ifdef PIPE_CTRL_FWD_EN
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL loaduse_one_cycle: got stall=%b expected 0", stall);
    end
    tick();
    n_vec++;
    if ({ex_ctrl, fwd_sel, wb_ctrl, wb_dst} !== {EX_R, 4'b0100, WB_LW, 5'd2}) begin
      n_err++;
      $display("FAIL loaduse_fwd_a: got ex=%b fwd=%b wb=%b dst=%0d expected 1100 0100 11 2",
               ex_ctrl, fwd_sel, wb_ctrl, wb_dst);
    end
`else
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL loaduse_mem_stall: got stall=%b expected 1", stall);
    end
    tick();
    n_vec++;
    if ({stall, wb_ctrl, wb_dst} !== {1'b0, WB_LW, 5'd2}) begin
      n_err++;
      $display("FAIL loaduse_release: got stall=%b wb=%b dst=%0d expected 0 11 2", stall, wb_ctrl, wb_dst);
    end
    tick();
    n_vec++;
    if ({ex_ctrl, fwd_sel} !== {EX_R, 4'b0000}) begin
      n_err++;
      $display("FAIL loaduse_issue: got ex=%b fwd=%b expected 1100 0000", ex_ctrl, fwd_sel);
    end
`endif
    drain();
  endtask

  task automatic test_forward();
    drive(EX_R, 3'b000, WB_R, 1'b0, 5'd1, 5'd2, 5'd3);
    tick();
    drive(EX_R, 3'b000, WB_R, 1'b0, 5'd4, 5'd3, 5'd6);
`ifdef PIPE_CTRL_FWD_EN
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL fwd_no_stall: got stall=%b expected 0", stall);
    end
    tick();
    n_vec++;
    if (fwd_sel !== 4'b0010) begin
      n_err++;
      $display("FAIL fwd_b_exmem: got fwd=%b expected 0010", fwd_sel);
    end
`else
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL raw_ex_stall: got stall=%b expected 1", stall);
    end
    tick();
    n_vec++;
    if ({stall, ex_ctrl} !== {1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL raw_mem_stall: got stall=%b ex=%b expected 1 0000", stall, ex_ctrl);
    end
    tick();
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL raw_release: got stall=%b expected 0", stall);
    end
    tick();
    n_vec++;
    if ({ex_ctrl, fwd_sel} !== {EX_R, 4'b0000}) begin
      n_err++;
      $display("FAIL raw_issue: got ex=%b fwd=%b expected 1100 0000", ex_ctrl, fwd_sel);
    end
`endif
    drain();
    // Producer targets $0 and consumer reads $0: no dependency at all
    drive(EX_R, 3'b000, WB_R, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    drive(EX_R, 3'b000, WB_R, 1'b0, 5'd0, 5'd0, 5'd7);
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL zero_reg_stall: got stall=%b expected 0", stall);
    end
    tick();
    n_vec++;
    if ({ex_ctrl, fwd_sel} !== {EX_R, 4'b0000}) begin
      n_err++;
      $display("FAIL zero_reg_fwd: got ex=%b fwd=%b expected 1100 0000", ex_ctrl, fwd_sel);
    end
    drain();
  endtask

  task automatic test_branch();
    drive(EX_BEQ, MEM_BR, 2'b00, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    alu_zero = 1'b1;
    drive(EX_LW, MEM_LW, WB_LW, 1'b0, 5'd9, 5'd8, 5'd0);
    n_vec++;
    if (pc_src !== 1'b0) begin
      n_err++;
      $display("FAIL branch_early: got pc_src=%b expected 0", pc_src);
    end
    tick();
    alu_zero = 1'b0;
    drive(EX_R, 3'b000, WB_R, 1'b0, 5'd8, 5'd13, 5'd11);
    n_vec++;
    if ({pc_src, flush_ifid, stall, ex_ctrl} !== {3'b110, EX_LW}) begin
      n_err++;
      $display("FAIL branch_taken: got pc_src=%b flush=%b stall=%b ex=%b expected 1 1 0 0001",
               pc_src, flush_ifid, stall, ex_ctrl);
    end
    tick();
    drive('0, '0, '0, 1'b0, '0, '0, '0);
    n_vec++;
    if ({ex_ctrl, mem_ctrl, pc_src, wb_ctrl} !== 9'd0) begin
      n_err++;
      $display("FAIL branch_squash: got ex=%b mem=%b pc_src=%b wb=%b expected zeros",
               ex_ctrl, mem_ctrl, pc_src, wb_ctrl);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (wb_ctrl !== 2'b00) begin
        n_err++;
        $display("FAIL branch_younger_wb%0d: got wb=%b expected 00", i, wb_ctrl);
      end
    end
    drain();
  endtask

  task automatic test_jump();
    drive(4'b0000, MEM_BR, 2'b00, 1'b1, 5'd0, 5'd0, 5'd0);
    n_vec++;
    if ({flush_ifid, pc_src} !== 2'b10) begin
      n_err++;
      $display("FAIL jump_flush: got flush=%b pc_src=%b expected 1 0", flush_ifid, pc_src);
    end
    tick();
    alu_zero = 1'b1;
    drive('0, '0, '0, 1'b0, '0, '0, '0);
    tick();
    n_vec++;
    if ({pc_src, flush_ifid} !== 2'b00) begin
      n_err++;
      $display("FAIL jump_masked: got pc_src=%b flush=%b expected 0 0", pc_src, flush_ifid);
    end
    alu_zero = 1'b0;
    drain();
    // jr stalled behind a load must not flush yet
    drive(EX_LW, MEM_LW, WB_LW, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    drive(4'b0000, MEM_BR, 2'b00, 1'b1, 5'd2, 5'd0, 5'd0);
    n_vec++;
    if ({stall, flush_ifid} !== 2'b10) begin
      n_err++;
      $display("FAIL jr_stalled: got stall=%b flush=%b expected 1 0", stall, flush_ifid);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    drive(EX_LW, MEM_LW, WB_LW, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    drive(EX_R, 3'b000, WB_R, 1'b0, 5'd2, 5'd3, 5'd4);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (all_out !== 20'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: got %b expected all zero", all_out);
    end
    #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_nostall: got stall=%b expected 0", stall);
    end
    tick();
    n_vec++;
    if ({ex_ctrl, mem_ctrl} !== {EX_R, 2'b00}) begin
      n_err++;
      $display("FAIL reset_mid_capture: got ex=%b mem=%b expected 1100 00", ex_ctrl, mem_ctrl);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_forward();
    test_branch();
    test_jump();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
